mips_cpu_mem_arbiter: RTL and testbench
=======================================

# mips_cpu_mem_arbiter

Sequencer that lets the `mips_cpu_harvard` core run from a single shared, wait-stated memory bus instead of two combinational memories. It sits between the core's instruction and data ports and one memory port. For each CPU instruction it performs the instruction fetch, then the optional data access. It holds both results in registers and then pulses the core's `clk_enable` for exactly one cycle. Instantiated in the bus-based system top and in the arbiter bench.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000, address of the first fetch after reset; used only by test assertions, never by datapath logic.

Ports (clock and reset first):
- `clk` in 1: single system clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `active` in 1: core's `active` output; low means the core has halted.
- `clk_enable` out 1: step strobe to the core.
- `instr_address` in 32: core fetch address.
- `instr_readdata` out 32: registered fetched word.
- `data_address` in 32: core data address.
- `data_read` in 1: core data read request.
- `data_write` in 1: core data write request.
- `data_writedata` in 32: core store data.
- `data_readdata` out 32: registered load result.
- `mem_address` out 32: shared bus address.
- `mem_read` out 1: bus read strobe.
- `mem_write` out 1: bus write strobe.
- `mem_writedata` out 32: bus store data.
- `mem_readdata` in 32: bus read data, valid on the completing edge.
- `mem_waitrequest` in 1: bus stall; a transfer completes on a posedge where a strobe is high and `mem_waitrequest` is low.

## Operation
- States: FETCH, DATA, STEP, HALT.
- **FETCH**
  - Drives `mem_read=1` and `mem_address=instr_address`.
  - Holds while `mem_waitrequest` is high.
  - On completion, captures `mem_readdata` into `instr_readdata` and goes to DATA.
  - On entry, if `active` is low, goes to HALT instead and issues no strobe.
- **DATA**: the core's `data_*` outputs are now valid from the registered instruction.
  - If `data_write`: drive `mem_write=1`, `mem_address=data_address`, `mem_writedata=data_writedata`.
  - Else if `data_read`: drive `mem_read=1`, `mem_address=data_address`. On completion, capture `mem_readdata` into `data_readdata`.
  - Else: no strobe; go to STEP on the next edge.
  - Holds while `mem_waitrequest` is high, then goes to STEP.
- **STEP**: `clk_enable=1` for one cycle, no strobes, then goes to FETCH.
- **HALT**: no strobes and `clk_enable=0`. Left only by `reset`.
- `data_read` and `data_write` both high is a core protocol error. The write is performed, the read is ignored, and `data_readdata` is unchanged.
- Address, strobe and write data stay stable for the whole of a stalled transfer. No alignment checks; addresses pass through unmodified.
- `data_readdata` keeps its last value across non-load instructions.

## Timing
- **Reset**
  - While `reset` is high, `clk_enable=1` so the core's synchronous reset is sampled, and `mem_read` and `mem_write` are forced to 0 combinationally.
  - The register state after reset is FETCH, with `instr_readdata=0` and `data_readdata=0`.
  - `mem_address` and `mem_writedata` are don't-care while the strobes are low.
- **Reset mid-transfer**: strobes drop in the same cycle `reset` rises. The pending transfer is abandoned and never retried.
- **Minimum latency**: 3 cycles per instruction with zero wait states, whether or not there is a data access (FETCH, DATA, STEP). Each wait cycle adds 1.
- **First access**: the first fetch strobe appears in the first cycle after `reset` falls, at `instr_address` (RESET_VECTOR).
- `clk_enable` is never high in two consecutive cycles outside reset.

## Structure
- Shared package `mips_cpu_arb_pkg` contains:
  - the state enum typedef (FETCH, DATA, STEP, HALT);
  - the `RESET_VECTOR` default constant.
- A single module: one FSM plus two 32-bit capture registers. No sub-module is natural.

## Test plan
1. **Reset and zero-wait non-memory instructions**: reset for 2 cycles, zero-wait memory, ROM holding `addiu` instructions.
   - First `mem_read` is at 0xBFC00000 in cycle 1 after reset.
   - `clk_enable` pulses every 3rd cycle.
   - Fetch addresses increment by 4.
2. **Load with data wait states**: `lw` from address 0x4 holding 0x12345678, with 2 data wait cycles.
   - Exactly one `mem_read` at 0x4, held 3 cycles.
   - `data_readdata=0x12345678` when `clk_enable` pulses.
   - Instruction period is 5 cycles.
3. **Store**: `sw` of 0xDEADBEEF to 0x8, zero-wait.
   - One-cycle `mem_write` with `mem_address=0x8` and `mem_writedata=0xDEADBEEF`.
   - No `mem_read` in DATA.
4. **Read and write both high**: force `data_read` and `data_write` high together.
   - Only `mem_write` is issued.
   - `data_readdata` is unchanged.
5. **Reset mid-transfer**: assert reset in DATA while `mem_waitrequest` is high.
   - Strobes are 0 in the same cycle.
   - `clk_enable=1` during reset.
   - After release, refetch from 0xBFC00000.
6. **Halt**: `jr` to 0 so that `active` falls.
   - Arbiter enters HALT.
   - No `mem_read`, `mem_write` or `clk_enable` for 20 cycles.
   - A subsequent reset restarts fetching.

Source files
------------

// File: rtl/mips_cpu_arb_pkg.sv
// Shared types for the single-bus memory arbiter in front of the mips_cpu_harvard core.
// State encoding and the default boot address live here.
package mips_cpu_arb_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DATA  = 2'd1,
      STEP  = 2'd2,
      HALT  = 2'd3
   } arb_state_t;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/mips_cpu_mem_arbiter.sv
// Serialises the core's instruction fetch and data access onto one wait-stated bus,
// then steps the core for one cycle once both results are registered.
//
// state | meaning
// FETCH | read instruction word at instr_address (or halt if core inactive)
// DATA  | optional load/store at data_address; store wins if both requested
// STEP  | clk_enable pulse, core advances one instruction
// HALT  | core stopped; idle until reset
module mips_cpu_mem_arbiter
   import mips_cpu_arb_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        active,
   output logic        clk_enable,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest
);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic [31:0] r_instr;
   logic [31:0] r_data;
   logic        w_instr_cap;
   logic        w_data_cap;

   assign instr_readdata = r_instr;
   assign data_readdata  = r_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
         r_instr <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_instr_cap) r_instr <= mem_readdata;
         if (w_data_cap)  r_data  <= mem_readdata;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_instr_cap   = 1'b0;
      w_data_cap    = 1'b0;
      clk_enable    = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = instr_address;
      mem_writedata = data_writedata;
      // Reset keeps the core stepping so it samples its own synchronous reset.
      if (reset) begin
         clk_enable = 1'b1;
      end else begin
         case (r_state)
            FETCH: begin
               if (!active) begin
                  w_next = HALT;
               end else begin
                  mem_read = 1'b1;
                  if (!mem_waitrequest) begin
                     w_instr_cap = 1'b1;
                     w_next      = DATA;
                  end
               end
            end
            DATA: begin
               mem_address = data_address;
               if (data_write) begin
                  mem_write = 1'b1;
                  if (!mem_waitrequest) w_next = STEP;
               end else if (data_read) begin
                  mem_read = 1'b1;
                  if (!mem_waitrequest) begin
                     w_data_cap = 1'b1;
                     w_next     = STEP;
                  end
               end else begin
                  w_next = STEP;
               end
            end
            STEP: begin
               clk_enable = 1'b1;
               w_next     = FETCH;
            end
            HALT: w_next = HALT;
            default: w_next = FETCH;
         endcase
      end
   end

   a_boot_fetch: assert property (@(posedge clk) $fell(reset) |-> (instr_address == RESET_VECTOR));

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter: the bench plays both the core and a wait-stated memory.
module tb_mips_cpu_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        active;
   logic        clk_enable;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;

   int          n_vec;
   int          n_bad;
   logic [31:0] pc;

   mips_cpu_mem_arbiter #(.RESET_VECTOR(32'hBFC00000)) dut (
      .clk            (clk),
      .reset          (reset),
      .active         (active),
      .clk_enable     (clk_enable),
      .instr_address  (instr_address),
      .instr_readdata (instr_readdata),
      .data_address   (data_address),
      .data_read      (data_read),
      .data_write     (data_write),
      .data_writedata (data_writedata),
      .data_readdata  (data_readdata),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_readdata   (mem_readdata),
      .mem_waitrequest(mem_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h4)  return 32'h12345678;
      if (a == 32'h10) return 32'h0BADF00D;
      return 32'h24080000 | {16'h0, a[15:0]};
   endfunction

   // Garbage while stalled so an early capture is visible.
   always_comb mem_readdata = mem_waitrequest ? 32'hA5A5A5A5 : rom(mem_address);

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         n_vec++;
         if (clk_enable !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold[%0d] got ce=%b rd=%b wr=%b want ce=1 rd=0 wr=0", i, clk_enable, mem_read, mem_write);
         end
      end
      tick();
      reset = 1'b0;
      pc = 32'hBFC00000;
      instr_address = pc;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL first_fetch got rd=%b addr=%h want rd=1 addr=bfc00000", mem_read, mem_address);
      end
      n_vec++;
      if (instr_readdata !== 32'h0 || data_readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_regs got ir=%h dr=%h want 0 0", instr_readdata, data_readdata);
      end
   endtask

   task automatic test_addiu();
      for (int k = 0; k < 3; k++) begin
         instr_address = pc; data_read = 1'b0; data_write = 1'b0; mem_waitrequest = 1'b0;
         #1;
         n_vec++;
         if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== pc || clk_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL addiu_fetch[%0d] got rd=%b wr=%b addr=%h ce=%b want 1 0 %h 0", k, mem_read, mem_write, mem_address, clk_enable, pc);
         end
         tick(); #1;
         n_vec++;
         if (mem_read !== 1'b0 || mem_write !== 1'b0 || clk_enable !== 1'b0 || instr_readdata !== rom(pc)) begin
            n_bad++;
            $display("FAIL addiu_data[%0d] got rd=%b wr=%b ce=%b ir=%h want 0 0 0 %h", k, mem_read, mem_write, clk_enable, instr_readdata, rom(pc));
         end
         tick(); #1;
         n_vec++;
         if (clk_enable !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL addiu_step[%0d] got ce=%b rd=%b wr=%b want 1 0 0", k, clk_enable, mem_read, mem_write);
         end
         tick();
         pc = pc + 32'd4;
      end
   endtask

   task automatic test_load_wait();
      instr_address = pc; mem_waitrequest = 1'b0;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== pc || clk_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL lw_fetch got rd=%b addr=%h ce=%b want 1 %h 0", mem_read, mem_address, clk_enable, pc);
      end
      for (int w = 0; w < 3; w++) begin
         tick();
         data_read = 1'b1; data_address = 32'h4; mem_waitrequest = (w < 2);
         #1;
         n_vec++;
         if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h4 || clk_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_data[%0d] got rd=%b wr=%b addr=%h ce=%b want 1 0 00000004 0", w, mem_read, mem_write, mem_address, clk_enable);
         end
         if (w < 2) begin
            n_vec++;
            if (data_readdata !== 32'h0) begin
               n_bad++;
               $display("FAIL lw_early_cap[%0d] got dr=%h want 00000000", w, data_readdata);
            end
         end
      end
      tick();
      mem_waitrequest = 1'b0;
      #1;
      n_vec++;
      if (clk_enable !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || data_readdata !== 32'h12345678) begin
         n_bad++;
         $display("FAIL lw_step got ce=%b rd=%b wr=%b dr=%h want 1 0 0 12345678", clk_enable, mem_read, mem_write, data_readdata);
      end
      tick();
      data_read = 1'b0;
      pc = pc + 32'd4;
   endtask

   task automatic test_store();
      instr_address = pc; mem_waitrequest = 1'b1;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== pc) begin
         n_bad++;
         $display("FAIL sw_fetch_stall got rd=%b addr=%h want 1 %h", mem_read, mem_address, pc);
      end
      tick();
      mem_waitrequest = 1'b0;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== pc || instr_readdata !== rom(pc - 32'd4)) begin
         n_bad++;
         $display("FAIL sw_fetch_done got rd=%b addr=%h ir=%h want 1 %h %h", mem_read, mem_address, instr_readdata, pc, rom(pc - 32'd4));
      end
      tick();
      data_write = 1'b1; data_address = 32'h8; data_writedata = 32'hDEADBEEF;
      #1;
      n_vec++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h8 || mem_writedata !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL sw_data got wr=%b rd=%b addr=%h wd=%h want 1 0 00000008 deadbeef", mem_write, mem_read, mem_address, mem_writedata);
      end
      tick(); #1;
      n_vec++;
      if (clk_enable !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0 ||
          data_readdata !== 32'h12345678 || instr_readdata !== rom(pc)) begin
         n_bad++;
         $display("FAIL sw_step got ce=%b wr=%b rd=%b dr=%h ir=%h want 1 0 0 12345678 %h", clk_enable, mem_write, mem_read, data_readdata, instr_readdata, rom(pc));
      end
      tick();
      data_write = 1'b0;
      pc = pc + 32'd4;
   endtask

   task automatic test_read_write_both();
      instr_address = pc; mem_waitrequest = 1'b0;
      #1;
      tick();
      for (int w = 0; w < 2; w++) begin
         data_read = 1'b1; data_write = 1'b1; data_address = 32'h10; data_writedata = 32'hCAFEF00D;
         mem_waitrequest = (w == 0);
         #1;
         n_vec++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h10 || mem_writedata !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL both_data[%0d] got wr=%b rd=%b addr=%h wd=%h want 1 0 00000010 cafef00d", w, mem_write, mem_read, mem_address, mem_writedata);
         end
         tick();
      end
      mem_waitrequest = 1'b0;
      #1;
      n_vec++;
      if (clk_enable !== 1'b1 || data_readdata !== 32'h12345678) begin
         n_bad++;
         $display("FAIL both_step got ce=%b dr=%h want 1 12345678", clk_enable, data_readdata);
      end
      tick();
      data_read = 1'b0; data_write = 1'b0;
      pc = pc + 32'd4;
   endtask

   task automatic test_reset_mid_transfer();
      instr_address = pc; mem_waitrequest = 1'b0;
      #1;
      tick();
      data_read = 1'b1; data_address = 32'h4; mem_waitrequest = 1'b1;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== 32'h4) begin
         n_bad++;
         $display("FAIL mid_pre got rd=%b addr=%h want 1 00000004", mem_read, mem_address);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || clk_enable !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_drop got rd=%b wr=%b ce=%b want 0 0 1", mem_read, mem_write, clk_enable);
      end
      tick(); #1;
      n_vec++;
      if (mem_read !== 1'b0 || clk_enable !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_hold got rd=%b ce=%b want 0 1", mem_read, clk_enable);
      end
      tick();
      reset = 1'b0; data_read = 1'b0; mem_waitrequest = 1'b0;
      pc = 32'hBFC00000; instr_address = pc;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== 32'hBFC00000 || instr_readdata !== 32'h0 || data_readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL mid_refetch got rd=%b addr=%h ir=%h dr=%h want 1 bfc00000 0 0", mem_read, mem_address, instr_readdata, data_readdata);
      end
      tick(); #1;
      n_vec++;
      if (instr_readdata !== rom(32'hBFC00000) || mem_read !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_data got ir=%h rd=%b want %h 0", instr_readdata, mem_read, rom(32'hBFC00000));
      end
      tick(); #1;
      n_vec++;
      if (clk_enable !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_step got ce=%b want 1", clk_enable);
      end
      tick();
   endtask

   task automatic test_halt();
      active = 1'b0; instr_address = 32'h0;
      #1;
      n_vec++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || clk_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_entry got rd=%b wr=%b ce=%b want 0 0 0", mem_read, mem_write, clk_enable);
      end
      for (int i = 0; i < 20; i++) begin
         tick(); #1;
         n_vec++;
         if (mem_read !== 1'b0 || mem_write !== 1'b0 || clk_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_idle[%0d] got rd=%b wr=%b ce=%b want 0 0 0", i, mem_read, mem_write, clk_enable);
         end
      end
      reset = 1'b1; active = 1'b1;
      #1;
      n_vec++;
      if (clk_enable !== 1'b1 || mem_read !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_reset got ce=%b rd=%b want 1 0", clk_enable, mem_read);
      end
      tick();
      reset = 1'b0; pc = 32'hBFC00000; instr_address = pc;
      #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL halt_restart got rd=%b addr=%h want 1 bfc00000", mem_read, mem_address);
      end
      tick(); #1;
      n_vec++;
      if (instr_readdata !== rom(32'hBFC00000)) begin
         n_bad++;
         $display("FAIL halt_refetch_data got ir=%h want %h", instr_readdata, rom(32'hBFC00000));
      end
      tick(); #1;
      n_vec++;
      if (clk_enable !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_restart_step got ce=%b want 1", clk_enable);
      end
   endtask

   initial begin
      n_vec = 0; n_bad = 0;
      reset = 1'b1; active = 1'b1; pc = 32'hBFC00000;
      instr_address = 32'hBFC00000; data_address = 32'h0;
      data_read = 1'b0; data_write = 1'b0; data_writedata = 32'h0;
      mem_waitrequest = 1'b0;
      test_reset();
      test_addiu();
      test_load_wait();
      test_store();
      test_read_write_both();
      test_reset_mid_transfer();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
